// File: rtl/shift_scale_seq_if.sv
// Handshake bundle for shift_scale_seq: operand side (in_*) and result side (out_*).
// Both sides are valid/ready: a transfer happens on a rising clk edge where valid and
// ready are both high; the producer holds valid (and its data) steady until that edge,
// and the consumer may raise or drop ready freely.
interface shift_scale_seq_if #(
  parameter int W = 16
);
  localparam int SHW = $clog2(W);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [SHW-1:0] in_amt;
  logic           in_signed;
  logic           in_round;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           busy;

  // Upstream/downstream stage driving operands and consuming results.
  modport master (
    output in_valid, in_data, in_amt, in_signed, in_round, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // The shifter itself.
  modport slave (
    input  in_valid, in_data, in_amt, in_signed, in_round, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_scale_seq.sv
// Sequential right-shifter: divides a W-bit operand by 2^amt one bit per clock,
// with logical or arithmetic fill and optional round-half-up from the last bit out.
// Flow per transaction: IDLE (accept) -> SHIFT (amt edges) -> ROUND -> HOLD (present).
module shift_scale_seq #(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_scale_seq_if.slave   bus,
  output logic [1:0]         dbg_state_o
);
  localparam int SHW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ROUND = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           rbit_q, rbit_d;
  logic           signed_q, signed_d;
  logic           round_q, round_d;
  logic           accept;

  assign bus.in_ready  = rst_n & (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_data  = data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

  assign accept = bus.in_valid & bus.in_ready;

  // State register and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      rbit_q   <= 1'b0;
      signed_q <= 1'b0;
      round_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      rbit_q   <= rbit_d;
      signed_q <= signed_d;
      round_q  <= round_d;
    end
  end

  // Next-state and datapath update: capture, shift one bit, round once, then hold.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    rbit_d   = rbit_q;
    signed_d = signed_q;
    round_d  = round_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d   = bus.in_data;
          cnt_d    = bus.in_amt;
          signed_d = bus.in_signed;
          round_d  = bus.in_round;
          rbit_d   = 1'b0;
          state_d  = (bus.in_amt != '0) ? S_SHIFT : S_ROUND;
        end
      end
      S_SHIFT: begin
        // The bit falling off the bottom is remembered for rounding.
        rbit_d = data_q[0];
        data_d = {signed_q & data_q[W-1], data_q[W-1:1]};
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        // rbit can only be set after at least one shift, so the top bit has room.
        data_d  = data_q + {{(W-1){1'b0}}, round_q & rbit_q};
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_shift_scale_seq.sv
// Bench for shift_scale_seq at W=16: directed vector table, hold/stall and
// mid-transaction reset sequences, then randomized transactions against a
// division-based reference model.
module tb_shift_scale_seq;
  localparam int W   = 16;
  localparam int SHW = 4;

  typedef struct {
    logic [W-1:0] data;
    int           amt;
    bit           sgn;
    bit           rnd;
    logic [W-1:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int n_cmp;
  int n_fail;
  logic [W-1:0] exp_q[$];

  shift_scale_seq_if #(.W(W)) bus ();

  shift_scale_seq #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor division by 2^amt on the operand's numeric value, plus one
  // when rounding is asked for and the discarded remainder is at least half.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt,
                                         input bit s, input bit r);
    longint v, dv, q, rem;
    v  = s ? longint'($signed(d)) : longint'(d);
    dv = longint'(1) << amt;
    q  = v / dv;
    if ((v % dv) != 0 && v < 0) q = q - 1;
    rem = v - q * dv;
    if (r && amt > 0 && rem >= dv / 2) q = q + 1;
    return q[W-1:0];
  endfunction

  // Drives one transaction from just after a clock edge; optionally stalls the
  // result in HOLD for 'stall' cycles while pulsing in_valid.
  task automatic run_txn(input logic [W-1:0] d, input int amt, input bit s, input bit r,
                         input logic [W-1:0] exp, input int stall, input bit pulse);
    int guard;
    int lat;
    logic [W-1:0] held;
    bus.in_data   = d;
    bus.in_amt    = SHW'(amt);
    bus.in_signed = s;
    bus.in_round  = r;
    bus.in_valid  = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    // Inputs after the accept edge must not matter.
    bus.in_data   = W'($urandom);
    bus.in_amt    = SHW'($urandom);
    bus.in_signed = 1'($urandom);
    bus.in_round  = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      check("busy_during_calc", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(amt + 1));
    if (!bus.out_valid) begin
      void'(exp_q.pop_front());
      return;
    end
    held = bus.out_data;
    for (int k = 0; k < stall; k++) begin
      if (pulse) bus.in_valid = ~bus.in_valid;
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(held));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("result", 32'(bus.out_data), 32'(exp_q.pop_front()));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_data_kept", 32'(bus.out_data), 32'(held));
  endtask

  vec_t vecs[7];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{data: 16'hABCD, amt: 1,  sgn: 1'b0, rnd: 1'b0, exp: 16'h55E6};
    vecs[1] = '{data: 16'h8000, amt: 4,  sgn: 1'b1, rnd: 1'b0, exp: 16'hF800};
    vecs[2] = '{data: 16'hFFF9, amt: 1,  sgn: 1'b1, rnd: 1'b1, exp: 16'hFFFD};
    vecs[3] = '{data: 16'hFFFF, amt: 15, sgn: 1'b0, rnd: 1'b1, exp: 16'h0002};
    vecs[4] = '{data: 16'h1234, amt: 0,  sgn: 1'b0, rnd: 1'b1, exp: 16'h1234};
    vecs[5] = '{data: 16'h8001, amt: 15, sgn: 1'b1, rnd: 1'b1, exp: 16'hFFFF};
    vecs[6] = '{data: 16'h0003, amt: 1,  sgn: 1'b0, rnd: 1'b1, exp: 16'h0002};

    // Reset behaviour
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_signed = 1'b0;
    bus.in_round  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].data, vecs[i].amt, vecs[i].sgn, vecs[i].rnd, vecs[i].exp, 1, 1'b0);
    end

    // Result stalled 5 cycles in HOLD with in_valid pulsing
    run_txn(16'h00F0, 4, 1'b0, 1'b0, 16'h000F, 5, 1'b1);
    @(posedge clk); #1;
    check("no_accept_after_hold", 32'(bus.busy), 32'd0);

    // Reset for one cycle in the middle of SHIFT
    bus.in_data   = 16'hFFFF;
    bus.in_amt    = SHW'(10);
    bus.in_signed = 1'b0;
    bus.in_round  = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mid_busy", 32'(bus.busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out_data", 32'(bus.out_data), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        if (bus.out_valid) seen = 1'b1;
      end
      check("abort_no_partial", 32'(seen), 32'd0);
    end
    run_txn(16'h0100, 8, 1'b0, 1'b0, 16'h0001, 0, 1'b0);

    // Randomized transactions against the reference model
    for (int t = 0; t < 250; t++) begin
      logic [W-1:0] d;
      int a;
      bit s, r;
      d = W'($urandom);
      a = $urandom_range(0, W - 1);
      s = 1'($urandom);
      r = 1'($urandom);
      if (t % 8 == 0) d = s ? 16'h8000 : 16'hFFFF;
      run_txn(d, a, s, r, model(d, a, s, r), $urandom_range(0, 3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
